jtframe_romrq: RTL

Game-side ROM request client: the initiator end of the SDRAM controller's `sdram_req`/`sdram_ack`/`data_rdy` read protocol. Each game ROM port (CPU, char, sprite) gets one instance between its address bus and the SDRAM arbiter. The block keeps 32-bit lines of recently fetched ROM, serves hits with zero latency, and on a miss issues one 32-bit SDRAM read and refills a line.

---
 rtl/jtframe_romrq_pkg.sv | 21 ++
 rtl/jtframe_romrq_line.sv | 38 +++
 rtl/jtframe_romrq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/jtframe_romrq_pkg.sv
// Shared types and constants for the jtframe_romrq ROM request client.
package jtframe_romrq_pkg;

    localparam int unsigned ROMRQ_SDRAM_AW = 22;
    localparam int unsigned ROMRQ_TAG_W    = 32;
    localparam int unsigned ROMRQ_DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } romrq_st_t;

    // Tags are stored zero-extended so the struct does not depend on AW
    typedef struct packed {
        logic                    valid;
        logic [ROMRQ_TAG_W-1:0]  tag;
        logic [ROMRQ_DATA_W-1:0] data;
    } romrq_line_t;

endpackage

// File: rtl/jtframe_romrq_line.sv
// One 32-bit ROM line: storage, tag compare and sub-word select.
module jtframe_romrq_line
    import jtframe_romrq_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned SW = 2
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     we,
    input  logic [ROMRQ_TAG_W-1:0]   wtag,
    input  logic [ROMRQ_DATA_W-1:0]  wdata,
    input  logic [ROMRQ_TAG_W-1:0]   tag,
    input  logic [SW-1:0]            sub,
    output logic                     hit_c,
    output logic [DW-1:0]            rd_c
);

    romrq_line_t line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (clr) begin
            line_q.valid <= 1'b0;
        end else if (we) begin
            line_q.valid <= 1'b1;
            line_q.tag   <= wtag;
            line_q.data  <= wdata;
        end
    end

    assign hit_c = line_q.valid && (line_q.tag == tag);
    // Sub-word k sits at bit k*DW; low addresses are the low bits
    assign rd_c  = DW'(line_q.data >> (32'(sub) * DW));

endmodule

// File: rtl/jtframe_romrq.sv
// Game-side ROM request client with a zero-latency line buffer in front of SDRAM.
// Define JTFRAME_ROMRQ_2LINE_EN for two lines with round-robin replacement.
module jtframe_romrq
    import jtframe_romrq_pkg::*;
#(
    parameter int unsigned              AW     = 18,
    parameter int unsigned              DW     = 8,
    parameter logic [ROMRQ_SDRAM_AW-1:0] OFFSET = 22'h0
)(
    input  logic                      clk_rom,
    input  logic                      rst,
    input  logic                      downloading,
    input  logic [AW-1:0]             addr,
    input  logic                      addr_ok,
    output logic [DW-1:0]             dout,
    output logic                      data_ok,
    output logic                      sdram_req,
    output logic [ROMRQ_SDRAM_AW-1:0] sdram_addr,
    input  logic                      sdram_ack,
    input  logic [ROMRQ_DATA_W-1:0]   data_read,
    input  logic                      data_rdy
);

    localparam int unsigned N     = 32 / DW;
    localparam int unsigned LOG2N = $clog2(N);
    localparam int unsigned SW    = (LOG2N == 0) ? 1 : LOG2N;
`ifdef JTFRAME_ROMRQ_2LINE_EN
    localparam int unsigned NL    = 2;
`else
    localparam int unsigned NL    = 1;
`endif

    romrq_st_t                 st, st_nx;
    logic                      req_nx;
    logic [ROMRQ_SDRAM_AW-1:0] addr_nx;
    logic [ROMRQ_TAG_W-1:0]    ltag, ltag_nx;
    logic [ROMRQ_TAG_W-1:0]    tag_c;
    logic [SW-1:0]             sub_c;
    logic                      fill_c;
    logic                      hit_c;
    logic [NL-1:0]             we_c;
    logic [NL-1:0]             hit_v;
    logic [DW-1:0]             rd_v [NL];
    logic [DW-1:0]             sel_c;
    logic [DW-1:0]             dout_q;

    assign tag_c = ROMRQ_TAG_W'(addr >> LOG2N);
    assign sub_c = SW'(addr & AW'(N - 1));

    for (genvar g = 0; g < NL; g++) begin : g_line
        jtframe_romrq_line #(.DW(DW), .SW(SW)) u_line (
            .clk   (clk_rom),
            .rst   (rst),
            .clr   (downloading),
            .we    (we_c[g]),
            .wtag  (ltag),
            .wdata (data_read),
            .tag   (tag_c),
            .sub   (sub_c),
            .hit_c (hit_v[g]),
            .rd_c  (rd_v[g])
        );
    end

`ifdef JTFRAME_ROMRQ_2LINE_EN
    logic ptr;

    // Round-robin victim pointer, advances on every fill
    always_ff @(posedge clk_rom) begin
        if (rst)         ptr <= 1'b0;
        else if (fill_c) ptr <= ~ptr;
    end

    assign we_c = {fill_c & ptr, fill_c & ~ptr};
`else
    assign we_c = fill_c;
`endif

    always_comb begin
        sel_c = '0;
        for (int i = 0; i < int'(NL); i++) begin
            if (hit_v[i]) sel_c = rd_v[i];
        end
    end

    assign hit_c   = addr_ok && (|hit_v);
    assign data_ok = hit_c && !downloading;
    // Hits pass straight through; otherwise the last served word is held
    assign dout    = hit_c ? sel_c : dout_q;

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            st         <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            ltag       <= '0;
            dout_q     <= '0;
        end else begin
            st         <= st_nx;
            sdram_req  <= req_nx;
            sdram_addr <= addr_nx;
            ltag       <= ltag_nx;
            dout_q     <= dout;
        end
    end

    always_comb begin
        st_nx   = st;
        req_nx  = sdram_req;
        addr_nx = sdram_addr;
        ltag_nx = ltag;
        fill_c  = 1'b0;
        case (st)
            IDLE: begin
                if (addr_ok && !hit_c && !downloading) begin
                    ltag_nx = tag_c;
                    addr_nx = ROMRQ_SDRAM_AW'(32'(OFFSET) + (tag_c << 1));
                    req_nx  = 1'b1;
                    st_nx   = REQ;
                end
            end
            REQ: begin
                if (downloading) begin
                    req_nx = 1'b0;
                    st_nx  = IDLE;
                end else if (sdram_ack) begin
                    req_nx = 1'b0;
                    if (data_rdy) begin
                        fill_c = 1'b1;
                        st_nx  = IDLE;
                    end else begin
                        st_nx  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (downloading) begin
                    st_nx = IDLE;
                end else if (data_rdy) begin
                    fill_c = 1'b1;
                    st_nx  = IDLE;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

endmodule
